// File: rtl/nvram_copy_ctrl.sv
// Store/recall copy engine between a working RAM and a shadow RAM, plus CPU access to the working RAM.
// Optional dirty tracking (skip a store when nothing changed) is enabled by defining NVRAM_DIRTY_TRACK_EN.
module nvram_copy_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    input  logic       store_req,
    input  logic       recall_req,
    output logic [7:0] wk_addr,
    output logic       wk_we,
    output logic [7:0] wk_din,
    input  logic [7:0] wk_dout,
    output logic [7:0] sh_addr,
    output logic       sh_we,
    output logic [7:0] sh_din,
    input  logic [7:0] sh_dout,
    output logic       busy,
    output logic       done,
    output logic       cpu_drop,
    output logic       dirty
);

    typedef enum logic [2:0] {IDLE, ST_RD, ST_WR, RC_RD, RC_WR} state_t;

    state_t     r_state;
    logic [7:0] r_idx;
    logic       r_store_q;
    logic       r_recall_q;
    logic       r_st_pend;
    logic       r_rc_pend;
    logic       r_done;

    logic       w_store_edge;
    logic       w_recall_edge;
    logic       w_st_pend;
    logic       w_rc_pend;
    logic       w_copy_last;
    logic       w_skip_store;

    assign w_store_edge  = store_req & ~r_store_q;
    assign w_recall_edge = recall_req & ~r_recall_q;
    // An edge seen while idle is acted on in the same cycle, so it starts the copy on the next edge.
    assign w_st_pend     = r_st_pend | w_store_edge;
    assign w_rc_pend     = r_rc_pend | w_recall_edge;
    assign w_copy_last   = ((r_state == ST_WR) || (r_state == RC_WR)) && (r_idx == 8'hFF);

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign cpu_dout = busy ? 8'hFF : wk_dout;
    assign cpu_drop = cpu_we & busy & ~reset;

`ifdef NVRAM_DIRTY_TRACK_EN
    logic r_dirty;
    logic w_cpu_accept;

    assign w_cpu_accept = cpu_we & ~busy & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dirty <= 1'b0;
        end else if (w_copy_last) begin
            r_dirty <= 1'b0;
        end else if (w_cpu_accept) begin
            r_dirty <= 1'b1;
        end
    end

    assign dirty        = r_dirty;
    assign w_skip_store = ~(r_dirty | w_cpu_accept);
`else
    assign dirty        = 1'b0;
    assign w_skip_store = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking everywhere here so every branch sees the pre-edge register values.
        r_store_q  <= store_req;
        r_recall_q <= recall_req;
        if (reset) begin
            r_state   <= RC_RD;
            r_idx     <= '0;
            r_st_pend <= 1'b0;
            r_rc_pend <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_store_edge)  r_st_pend <= 1'b1;
            if (w_recall_edge) r_rc_pend <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_rc_pend) begin
                        r_rc_pend <= 1'b0;
                        r_idx     <= '0;
                        r_state   <= RC_RD;
                    end else if (w_st_pend) begin
                        r_st_pend <= 1'b0;
                        r_idx     <= '0;
                        if (w_skip_store) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: r_state <= ST_WR;
                RC_RD: r_state <= RC_WR;
                ST_WR, RC_WR: begin
                    r_idx <= r_idx + 8'd1;
                    if (w_copy_last) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= (r_state == ST_WR) ? ST_RD : RC_RD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        wk_addr = '0;
        wk_we   = 1'b0;
        wk_din  = '0;
        sh_addr = '0;
        sh_we   = 1'b0;
        sh_din  = '0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    wk_addr = cpu_addr;
                    wk_we   = cpu_we;
                    wk_din  = cpu_din;
                end
                ST_RD: wk_addr = r_idx;
                ST_WR: begin
                    sh_addr = r_idx;
                    sh_we   = 1'b1;
                    sh_din  = wk_dout;
                end
                RC_RD: sh_addr = r_idx;
                RC_WR: begin
                    wk_addr = r_idx;
                    wk_we   = 1'b1;
                    wk_din  = sh_dout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/nvram_copy_ctrl.md
NVRAM_COPY_CTRL -- requirements
Module: nvram_copy_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: cpu_we  in  1  CPU write strobe (one cycle per write).
REQ-004 SHALL have ports: cpu_addr  in  8 / cpu_din  in  8 / cpu_dout  out  8  CPU access to working RAM.
REQ-005 SHALL have ports: store_req  in  1 / recall_req  in  1  level requests; rising edge triggers.
REQ-006 SHALL have ports: wk_addr  out  8 / wk_we  out  1 / wk_din  out  8 / wk_dout  in  8  working RAM port; read data one cycle after the address.
REQ-007 SHALL have ports: sh_addr  out  8 / sh_we  out  1 / sh_din  out  8 / sh_dout  in  8  shadow RAM port; same timing.
REQ-008 SHALL have ports: busy  out  1 copy in progress / done  out  1 one-cycle completion pulse / cpu_drop  out  1 one-cycle pulse when a CPU write is discarded / dirty  out  1 unsaved CPU writes exist.

Function
REQ-009 SHALL implement states IDLE, ST_RD, ST_WR, RC_RD, RC_WR with an 8-bit byte index idx.
REQ-010 SHALL in IDLE route the CPU port: wk_addr=cpu_addr, wk_we=cpu_we, wk_din=cpu_din; sh_we=0.
REQ-011 SHALL drive cpu_dout=wk_dout when busy=0 and 8'hFF when busy=1.
REQ-012 SHALL detect request edges by registering store_req and recall_req; an edge sets a one-deep pending flag for that request type, and repeated edges while pending are merged.
REQ-013 SHALL in IDLE start a pending recall before a pending store; on a simultaneous edge, recall runs first and store runs next.
REQ-014 SHALL in store: ST_RD drive wk_addr=idx, wk_we=0; ST_WR drive sh_addr=idx, sh_din=wk_dout, sh_we=1, then increment idx and return to ST_RD; ST_WR at idx=255 goes to IDLE.
REQ-015 SHALL in recall mirror REQ-014 with the roles swapped (read sh at idx, write wk at idx), using states RC_RD and RC_WR.
REQ-016 SHALL take exactly 512 cycles per copy: busy=1 from the first RD cycle through the final WR cycle, and done=1 in the cycle after the final WR.
REQ-017 SHALL set idx=0 at the start of every copy; idx wrap-around SHALL never be observable.
REQ-018 SHALL discard a cpu_we that occurs while busy=1, asserting cpu_drop in the same cycle and leaving the RAM unchanged.
REQ-019 SHALL latch request edges that arrive while busy and service them after done, with recall taking priority.
REQ-020 SHALL accept a new request edge in the same cycle that done is asserted and start it in the next cycle.

Reset
REQ-021 SHALL in any state on reset: clear pending flags; set idx=0; set done=0, cpu_drop=0, dirty=0, wk_we=0, sh_we=0, wk_addr=0, sh_addr=0, wk_din=0, sh_din=0.
REQ-022 SHALL on reset enter RC_RD with busy=1, so an automatic power-up recall runs immediately after reset is released; the first read cycle addresses sh idx 0.
REQ-023 SHALL abandon any copy in progress when reset is asserted mid-copy; the partially written destination is left as-is, and the automatic recall restarts.
REQ-024 SHALL keep the edge-detect registers at reset so that a request held high through reset does not trigger.

Configuration
REQ-025 SHALL compile dirty tracking only when macro NVRAM_DIRTY_TRACK_EN is defined.
REQ-026 SHALL with NVRAM_DIRTY_TRACK_EN behave as follows: an accepted CPU write sets dirty; completion of a store or recall clears dirty; a store started with dirty=0 skips the copy, giving busy=0, no sh_we, and done asserted in the cycle after the pending flag is consumed.
REQ-027 SHALL without NVRAM_DIRTY_TRACK_EN tie dirty to 0 and run every store as a full 512-cycle copy.

Verification
REQ-028 SHALL verify that with shadow preloaded sh[i]=i^8'hA5, after reset release busy stays high for 512 cycles, done pulses once, and wk[i]=i^8'hA5 for all i.
REQ-029 SHALL verify that CPU writes wk[0x10]=0x3C, then a store_req edge, result in sh[0x10]=0x3C, done exactly 513 cycles after the edge-detect cycle, and sh_we asserted exactly 256 times.
REQ-030 SHALL verify that a cpu_we during a store, at address 0x20 with data 0x77, gives cpu_drop=1 and a read of wk[0x20] afterwards returns its prior value; cpu_dout reads 0xFF while busy.
REQ-031 SHALL verify that simultaneous store_req and recall_req edges in IDLE run a recall (512 cycles), then a store (512 cycles), with two done pulses.
REQ-032 SHALL verify that reset asserted at store idx 0x80 restarts the power-up recall, with idx=0 and busy=1 after release.
REQ-033 SHALL verify with NVRAM_DIRTY_TRACK_EN that a store_req edge with no prior CPU write gives done after 1 cycle and no sh_we; after one CPU write, dirty=1 and the store runs the full 512 cycles, then dirty=0.
